// File: rtl/clap_sequencer.sv
// Clap-pattern detector: counts debounced rising edges on clap_i, aborts a
// partial sequence on an over-long gap, and flags completion after CLAPS_REQ claps.
module clap_sequencer #(
    parameter  int CLAPS_REQ = 2,
    parameter  int MIN_GAP   = 4,
    parameter  int MAX_GAP   = 20,
    parameter  int MODE      = 0,
    localparam int CNT_W     = $clog2(CLAPS_REQ + 1),
    localparam int GAP_W     = $clog2(MAX_GAP + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clap_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] clap_count_o,
    output logic             clap_set_o,
    output logic             clap_fail_o,
    output logic             busy_o
);

    // gap_cnt lags the edge distance k by one: it reads k-1 when sampled at an edge.
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0] GAP_TO   = GAP_W'(MAX_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ACC  = GAP_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLAPS_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           state;
    logic             clap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] count;
    logic             set_r;
    logic             fail_r;

    logic clap_edge;
    logic accept;
    logic timeout;
    logic complete;

    // gap_cnt parked at MAX_GAP means no acceptance since reset/clr/timeout,
    // so the refractory test passes on its own.
    always_comb begin
        clap_edge = clap_i & ~clap_q;
        accept    = clap_edge && (gap_cnt >= GAP_ACC);
        timeout   = (state == S_COUNT) && (gap_cnt == GAP_TO);
        complete  = accept && (count == CNT_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            clap_q  <= 1'b1;
            gap_cnt <= GAP_MAX;
            count   <= '0;
            set_r   <= 1'b0;
            fail_r  <= 1'b0;
        end else begin
            clap_q <= clap_i;
            fail_r <= 1'b0;
            if (MODE == 0) set_r <= 1'b0;

            if (clr_i) begin
                state   <= S_IDLE;
                count   <= '0;
                gap_cnt <= GAP_MAX;
            end else if (timeout) begin
                state   <= S_IDLE;
                count   <= '0;
                gap_cnt <= GAP_MAX;
                fail_r  <= 1'b1;
            end else if (accept) begin
                gap_cnt <= '0;
                if (complete) begin
                    state <= S_IDLE;
                    count <= '0;
                    set_r <= (MODE == 0) ? 1'b1 : ~set_r;
                end else begin
                    state <= S_COUNT;
                    count <= count + CNT_W'(1);
                end
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    assign clap_count_o = count;
    assign clap_set_o   = set_r;
    assign clap_fail_o  = fail_r;
    assign busy_o       = (state == S_COUNT);

endmodule

// File: tb/tb_clap_sequencer.sv
// Bench for clap_sequencer: three configurations driven in lockstep, checked
// against a table, hand sequences and a time-stamp based reference model.
module tb_clap_sequencer;

    localparam int NI = 3;
    localparam int REQ_P [NI] = '{2, 2, 3};
    localparam int MING_P[NI] = '{4, 4, 2};
    localparam int MAXG_P[NI] = '{20, 20, 9};
    localparam int MODE_P[NI] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n, clap, clr;
    logic [1:0] cnt_a, cnt_b, cnt_c;
    logic       set_a, set_b, set_c;
    logic       fail_a, fail_b, fail_c;
    logic       busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clap_sequencer #(.CLAPS_REQ(2), .MIN_GAP(4), .MAX_GAP(20), .MODE(0)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .clap_i(clap), .clr_i(clr),
        .clap_count_o(cnt_a), .clap_set_o(set_a), .clap_fail_o(fail_a), .busy_o(busy_a));
    clap_sequencer #(.CLAPS_REQ(2), .MIN_GAP(4), .MAX_GAP(20), .MODE(1)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .clap_i(clap), .clr_i(clr),
        .clap_count_o(cnt_b), .clap_set_o(set_b), .clap_fail_o(fail_b), .busy_o(busy_b));
    clap_sequencer #(.CLAPS_REQ(3), .MIN_GAP(2), .MAX_GAP(9), .MODE(0)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .clap_i(clap), .clr_i(clr),
        .clap_count_o(cnt_c), .clap_set_o(set_c), .clap_fail_o(fail_c), .busy_o(busy_c));

    // Reference model: remembers the cycle of the last accepted clap and
    // measures gaps by subtraction.
    longint cyc = 0;
    bit     m_prev;
    int     m_cnt  [NI];
    longint m_last [NI];
    bit     m_free [NI];
    bit     m_tog  [NI];
    bit     m_pulse[NI];
    bit     m_fail [NI];

    function automatic void model_reset();
        m_prev = 1'b1;
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0; m_free[i] = 1'b1; m_tog[i] = 1'b0;
            m_pulse[i] = 1'b0; m_fail[i] = 1'b0; m_last[i] = 0;
        end
    endfunction

    function automatic void model_tick(input bit c, input bit cl);
        bit rise;
        rise   = c && !m_prev;
        m_prev = c;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            longint k;
            k = cyc - m_last[i];
            m_pulse[i] = 1'b0;
            m_fail[i]  = 1'b0;
            if (cl) begin
                m_cnt[i] = 0; m_free[i] = 1'b1;
            end else if (m_cnt[i] > 0 && k == longint'(MAXG_P[i])) begin
                m_cnt[i] = 0; m_free[i] = 1'b1; m_fail[i] = 1'b1;
            end else if (rise && (m_free[i] || k >= longint'(MING_P[i]))) begin
                m_last[i] = cyc;
                m_free[i] = 1'b0;
                m_cnt[i]++;
                if (m_cnt[i] == REQ_P[i]) begin
                    m_cnt[i] = 0; m_pulse[i] = 1'b1; m_tog[i] = ~m_tog[i];
                end
            end
        end
    endfunction

    function automatic bit m_set(input int i);
        return (MODE_P[i] != 0) ? m_tog[i] : m_pulse[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("A count", 32'(cnt_a), m_cnt[0]);
        chk("A set",   32'(set_a), 32'(m_set(0)));
        chk("A fail",  32'(fail_a), 32'(m_fail[0]));
        chk("A busy",  32'(busy_a), 32'(m_cnt[0] != 0));
        chk("B count", 32'(cnt_b), m_cnt[1]);
        chk("B set",   32'(set_b), 32'(m_set(1)));
        chk("B fail",  32'(fail_b), 32'(m_fail[1]));
        chk("B busy",  32'(busy_b), 32'(m_cnt[1] != 0));
        chk("C count", 32'(cnt_c), m_cnt[2]);
        chk("C set",   32'(set_c), 32'(m_set(2)));
        chk("C fail",  32'(fail_c), 32'(m_fail[2]));
        chk("C busy",  32'(busy_c), 32'(m_cnt[2] != 0));
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic step(input bit c, input bit cl);
        clap = c;
        clr  = cl;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_tick(c, cl);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst A busy", 32'(busy_a), 0);
        chk("rst B set", 32'(set_b), 0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit clap;
        bit clr;
        int cnt;
        bit set;
        bit fail;
        bit busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit c, input bit cl, input int n,
                                input bit s, input bit f, input bit b);
        vec_t v;
        v.clap = c; v.clr = cl; v.cnt = n; v.set = s; v.fail = f; v.busy = b;
        tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    initial begin
        // Edges at 0 and 10 with a held level, idle, then edges 0, 2 (bounce), 8.
        add(1,0,1,0,0,1);
        for (int i = 1; i <= 3; i++) add(1,0,1,0,0,1);
        for (int i = 4; i <= 9; i++) add(0,0,1,0,0,1);
        add(1,0,0,1,0,0);
        add(0,0,0,0,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0,0,0);
        add(1,0,1,0,0,1);
        add(0,0,1,0,0,1);
        add(1,0,1,0,0,1);
        for (int i = 3; i <= 7; i++) add(0,0,1,0,0,1);
        add(1,0,0,1,0,0);
        add(0,0,0,0,0,0);

        rst_n = 1'b0; clap = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        chk("reset count", 32'(cnt_a), 0);
        chk("reset set",   32'(set_a), 0);
        chk("reset fail",  32'(fail_a), 0);
        chk("reset busy",  32'(busy_a), 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        idle(2);

        foreach (tbl[i]) begin
            step(tbl[i].clap, tbl[i].clr);
            chk($sformatf("T%0d count", i), 32'(cnt_a),  tbl[i].cnt);
            chk($sformatf("T%0d set", i),   32'(set_a),  32'(tbl[i].set));
            chk($sformatf("T%0d fail", i),  32'(fail_a), 32'(tbl[i].fail));
            chk($sformatf("T%0d busy", i),  32'(busy_a), 32'(tbl[i].busy));
        end

        // Timeout after k=20, fresh edge at 25, then an edge colliding with timeout.
        idle(6);
        step(1'b1, 1'b0);  chk("s3 first", 32'(cnt_a), 1);
        idle(18);
        step(1'b0, 1'b0);  chk("s3 k19 busy", 32'(busy_a), 1);
        step(1'b0, 1'b0);  chk("s3 fail", 32'(fail_a), 1); chk("s3 fail busy", 32'(busy_a), 0);
        step(1'b0, 1'b0);  chk("s3 fail one", 32'(fail_a), 0);
        idle(3);
        step(1'b1, 1'b0);  chk("s3 edge25", 32'(cnt_a), 1);
        idle(19);
        step(1'b1, 1'b0);  chk("s3 to wins fail", 32'(fail_a), 1); chk("s3 to wins cnt", 32'(cnt_a), 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);  chk("s3 after to", 32'(cnt_a), 1);

        // Async reset mid-sequence, then clap held high through release.
        reset_mid();
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            chk("s4 held", 32'(cnt_a), 0);
        end
        step(1'b0, 1'b0);

        // Toggle mode: two full sequences.
        idle(2);
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0);  chk("s5 B rise", 32'(set_b), 1); chk("s5 A pulse", 32'(set_a), 1);
        idle(19);          chk("s5 B hold", 32'(set_b), 1);
        step(1'b1, 1'b0);  chk("s5 edge30", 32'(cnt_a), 1);
        idle(9);
        step(1'b1, 1'b0);  chk("s5 B fall", 32'(set_b), 0);
        step(1'b0, 1'b0);

        // Clear coincident with an edge; next edge accepted immediately.
        idle(5);
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b1);  chk("s6 clr cnt", 32'(cnt_a), 0); chk("s6 clr set", 32'(set_a), 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);  chk("s6 after clr", 32'(cnt_a), 1);
        step(1'b0, 1'b1);

        // Random traffic with varying clap density, rare clears and resets.
        begin
            int p;
            bit lvl;
            p   = 4;
            lvl = 1'b0;
            for (int n = 0; n < 2500; n++) begin
                if (n % 50 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       p = 2;
                        1:       p = 5;
                        default: p = 12;
                    endcase
                end
                if ($urandom_range(0, 599) == 0) reset_mid();
                if ($urandom_range(1, p) == 1) lvl = ~lvl;
                step(lvl, $urandom_range(0, 59) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clap_sequencer.md
# clap_sequencer

Parametrised clap-pattern detector and successor to the two-state clap controller. It counts rising edges on a raw clap input and ignores edges inside a refractory window, which rejects bounce and echo. It aborts a partial sequence when the inter-clap gap exceeds a timeout, and signals completion once `CLAPS_REQ` accepted claps have arrived. It sits between the clap sensor front end and the control logic that consumes `clap_set_o`.

## Interface
Parameters:
- `CLAPS_REQ`, default 2: accepted claps that complete a sequence; must be ≥1.
- `MIN_GAP`, default 4: refractory length in cycles; must be ≥1.
- `MAX_GAP`, default 20: inter-clap timeout in cycles; must satisfy `MAX_GAP` > `MIN_GAP`.
- `MODE`, default 0: 0 = `clap_set_o` is a one-cycle pulse; 1 = `clap_set_o` toggles on each completion.
- Derived localparams: `CNT_W` = $clog2(`CLAPS_REQ`+1), `GAP_W` = $clog2(`MAX_GAP`+1).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `clap_i`  in  1  raw clap level, already synchronised, may stay high for many cycles.
- `clr_i`  in  1  synchronous abort of the current sequence.
- `clap_count_o`  out  `CNT_W`  accepted claps in the current sequence.
- `clap_set_o`  out  1  completion indication, behaviour set by `MODE`.
- `clap_fail_o`  out  1  one-cycle pulse when a partial sequence times out.
- `busy_o`  out  1  high while a partial sequence is in progress (state `S_COUNT`).

## Operation
- **Edge detection.**
  - `clap_q` is a registered copy of `clap_i`.
  - edge = `clap_i` & ~`clap_q`.
  - `clap_q` resets to 1, so `clap_i` held high through reset release produces no clap.
- **Gap counter.**
  - `gap_cnt` clears to 0 on every accepted edge and increments by 1 every cycle.
  - It saturates at `MAX_GAP` and resets to `MAX_GAP`.
  - Let k = clock edges since the last acceptance.
  - An edge is accepted iff k ≥ `MIN_GAP`, or if no acceptance has happened since reset, clr, or timeout.
- **States.**
  - `S_IDLE`: count is 0 and no timeout applies.
    - An accepted edge sets count to 1 and moves to `S_COUNT`.
    - If `CLAPS_REQ`==1 it completes instead: count stays 0, state stays `S_IDLE`.
  - `S_COUNT`: an accepted edge increments count.
    - When count would reach `CLAPS_REQ`, the sequence completes: count becomes 0, state goes to `S_IDLE`, and `clap_set_o` fires.
    - When k == `MAX_GAP`, the sequence times out: `clap_fail_o` pulses, count becomes 0, state goes to `S_IDLE`, and `gap_cnt` is forced to `MAX_GAP`.
- **After completion.**
  - The refractory window still applies to the first edge of the next sequence, since `gap_cnt` restarted at the completing clap.
- **`clap_set_o` by mode.**
  - `MODE`=0: high for exactly one cycle after the completing edge.
  - `MODE`=1: inverts on each completion and holds its level.
- **Priority:** reset > `clr_i` > timeout > accepted edge.
  - `clr_i`: count becomes 0, state `S_IDLE`, `gap_cnt` becomes `MAX_GAP`. A coincident edge is dropped and `clap_set_o` does not fire. `clap_q` still updates.
  - Timeout coinciding with an edge: the timeout wins and the edge is dropped.
  - `clr_i` never alters the `MODE`=1 toggle level.
- **Reset mid-operation.** All state returns to reset values immediately, with no fail or set pulse.

## Timing
- **Reset values:**
  - `clap_count_o`=0
  - `clap_set_o`=0
  - `clap_fail_o`=0
  - `busy_o`=0
  - internally: state `S_IDLE`, `clap_q`=1, `gap_cnt`=`MAX_GAP`
- **Latency.** An edge sampled at clock edge t updates `clap_count_o`, `busy_o` and `clap_set_o` after edge t, so they are visible in the cycle following t.
- **Timeout.** `clap_fail_o` is high in the cycle after clock edge k = `MAX_GAP`.
- **Registers.** All outputs are registered, with no combinational path from input to output.
- **Level holds.** A held-high `clap_i` counts once. A new clap needs a low cycle first.

## Test plan
All scenarios use `CLAPS_REQ`=2, `MIN_GAP`=4, `MAX_GAP`=20, `MODE`=0 unless noted.
1. Edges at cycles 0 and 10 -> count 1 after cycle 0; `clap_set_o` pulses once after cycle 10; count 0, `busy_o` 0.
2. Edges at 0, 2 (bounce) and 8 -> edge at 2 ignored with count held at 1; set pulse after 8.
3. Edge at 0 and nothing after -> `clap_fail_o` one-cycle pulse after k=20; count 0, `busy_o` 0; an edge at 25 gives count 1. Also edges at 0 and 20 -> the timeout wins and the edge at 20 is dropped.
4. `clap_i` high before and through `rst_n_i` release, held 10 cycles -> count stays 0. Separately, assert `rst_n_i` low mid-sequence with count 1 -> all outputs 0 immediately.
5. `MODE`=1, two full sequences (edges at 0, 10, 30, 40) -> `clap_set_o` goes 0→1 after 10 and 1→0 after 40.
6. Edge at 0, then `clr_i` coincident with an edge at 10 -> count 0, no set; the next edge at 12 is accepted immediately as count 1.
